// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit ALU among N_REQ requesters.
// One operation in flight at a time; a bounded wait aborts operations the ALU never completes.
module alu_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [5*N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0]   req_in1,
  input  logic [8*N_REQ-1:0]   req_in2,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [4:0]           rsp_status,
  output logic                 rsp_err,
  output logic                 alu_enable,
  output logic [7:0]           alu_in1,
  output logic [7:0]           alu_in2,
  output logic [4:0]           alu_op,
  input  logic [7:0]           alu_out,
  input  logic [4:0]           alu_status,
  input  logic                 alu_ready
);

  localparam int DATA_W = 8;
  localparam int OP_W   = 5;
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]    owner, owner_nxt;
  logic [PTR_W-1:0]    pick;
  logic                found;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;

  logic [N_REQ-1:0]    gnt_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt, alu_in1_nxt, alu_in2_nxt;
  logic [OP_W-1:0]     rsp_status_nxt, alu_op_nxt;
  logic                rsp_err_nxt, alu_enable_nxt;

  // Rotating-priority search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    owner_nxt      = owner;
    wait_cnt_nxt   = wait_cnt;
    gnt_nxt        = '0;
    rsp_valid_nxt  = '0;
    alu_enable_nxt = alu_enable;
    alu_in1_nxt    = alu_in1;
    alu_in2_nxt    = alu_in2;
    alu_op_nxt     = alu_op;
    rsp_data_nxt   = rsp_data;
    rsp_status_nxt = rsp_status;
    rsp_err_nxt    = rsp_err;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = ISSUE;
          gnt_nxt[pick]  = 1'b1;
          owner_nxt      = pick;
          rr_ptr_nxt     = (pick == PTR_LAST) ? '0 : pick + 1'b1;
          wait_cnt_nxt   = '0;
          alu_enable_nxt = 1'b1;
          alu_op_nxt     = req_op[OP_W*pick +: OP_W];
          alu_in1_nxt    = req_in1[DATA_W*pick +: DATA_W];
          alu_in2_nxt    = req_in2[DATA_W*pick +: DATA_W];
        end
      end
      ISSUE: begin
        // The response pulse is registered here so it appears in the RESP cycle.
        if (alu_ready) begin
          state_nxt             = RESP;
          alu_enable_nxt        = 1'b0;
          rsp_data_nxt          = alu_out;
          rsp_status_nxt        = alu_status;
          rsp_err_nxt           = 1'b0;
          rsp_valid_nxt[owner]  = 1'b1;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt             = RESP;
          alu_enable_nxt        = 1'b0;
          rsp_data_nxt          = '0;
          rsp_status_nxt        = '0;
          rsp_err_nxt           = 1'b1;
          rsp_valid_nxt[owner]  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      wait_cnt   <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      alu_enable <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      wait_cnt   <= wait_cnt_nxt;
      gnt        <= gnt_nxt;
      rsp_valid  <= rsp_valid_nxt;
      alu_enable <= alu_enable_nxt;
      alu_in1    <= alu_in1_nxt;
      alu_in2    <= alu_in2_nxt;
      alu_op     <= alu_op_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_status <= rsp_status_nxt;
      rsp_err    <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized requesters and ALU responder,
// a round-robin reference model predicting grants, and a decoupled response monitor.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int T = 16;
  localparam int M_OFF  = 0;
  localparam int M_ALL  = 1;
  localparam int M_RAND = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [5*N-1:0]   req_op = '0;
  logic [8*N-1:0]   req_in1 = '0;
  logic [8*N-1:0]   req_in2 = '0;
  logic [N-1:0]     gnt, rsp_valid;
  logic [7:0]       rsp_data;
  logic [4:0]       rsp_status;
  logic             rsp_err;
  logic             alu_enable;
  logic [7:0]       alu_in1, alu_in2;
  logic [4:0]       alu_op;
  logic [7:0]       alu_out = '0;
  logic [4:0]       alu_status = '0;
  logic             alu_ready = 1'b0;

  alu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_err(rsp_err),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status), .alu_ready(alu_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [7:0] data;
    logic [4:0] status;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  int   mode    = M_OFF;
  int   fixed_d = -1;
  logic [N-1:0] inj_mask = '0;
  logic [4:0]   inj_op  [N];
  logic [7:0]   inj_in1 [N];
  logic [7:0]   inj_in2 [N];

  // reference model state
  bit         m_idle = 1'b1;
  bit         m_busy = 1'b0;
  int         m_ptr  = 0;
  int         m_g = 0, m_d = 0, m_rsp_cyc = 0;
  logic [7:0] m_in1 = '0, m_in2 = '0;
  logic [4:0] m_op = '0;

  int dly_tbl[12] = '{0, 0, 1, 1, 2, 3, 4, 14, 15, 15, 16, 20};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_rr(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [7:0] alu_data(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    return (op == 5'h01) ? a + b : (a ^ b) + {3'b000, op};
  endfunction

  function automatic logic [4:0] alu_stat(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    return (op == 5'h01) ? 5'h00 : (a[4:0] ^ b[4:0] ^ op);
  endfunction

  task automatic raise(input int k, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    req[k]            = 1'b1;
    req_op[5*k +: 5]  = op;
    req_in1[8*k +: 8] = a;
    req_in2[8*k +: 8] = b;
  endtask

  // Stimulus, ALU responder and grant/issue prediction, all at the negative edge.
  always @(negedge clk) begin : stim
    int   w;
    bit   exp_en;
    exp_t e;
    if (!reset_n) begin
      m_idle = 1'b1; m_busy = 1'b0; m_ptr = 0; alu_ready = 1'b0;
    end else begin
      if (m_idle && req != '0) begin
        w = pick_rr(req, m_ptr);
        chk("gnt_winner", 32'(gnt), 32'(1) << w);
        m_ptr  = (w + 1) % N;
        m_idle = 1'b0;
        m_busy = 1'b1;
        m_g    = cyc;
        m_op   = req_op[5*w +: 5];
        m_in1  = req_in1[8*w +: 8];
        m_in2  = req_in2[8*w +: 8];
        m_d    = (fixed_d >= 0) ? fixed_d : dly_tbl[$urandom_range(0, 11)];
        e.who    = w;
        e.err    = (m_d >= T);
        e.data   = e.err ? 8'h00 : alu_data(m_op, m_in1, m_in2);
        e.status = e.err ? 5'h00 : alu_stat(m_op, m_in1, m_in2);
        e.cyc    = e.err ? cyc + T : cyc + m_d + 1;
        m_rsp_cyc = e.cyc;
        sb_q.push_back(e);
      end else begin
        chk("gnt_quiet", 32'(gnt), 32'h0);
      end

      exp_en = m_busy && (cyc < m_rsp_cyc);
      chk("alu_enable", 32'(alu_enable), 32'(exp_en));
      if (exp_en) begin
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("alu_in1", 32'(alu_in1), 32'(m_in1));
        chk("alu_in2", 32'(alu_in2), 32'(m_in2));
      end

      if (exp_en && (cyc - m_g == m_d)) begin
        alu_ready  = 1'b1;
        alu_out    = alu_data(m_op, m_in1, m_in2);
        alu_status = alu_stat(m_op, m_in1, m_in2);
      end else begin
        alu_ready  = exp_en ? 1'b0 : ($urandom_range(0, 2) == 0);
        alu_out    = 8'($urandom);
        alu_status = 5'($urandom);
      end

      if (m_busy && cyc == m_rsp_cyc + 1) begin
        m_busy = 1'b0;
        m_idle = 1'b1;
      end

      for (int k = 0; k < N; k++) begin
        if (inj_mask[k]) begin
          raise(k, inj_op[k], inj_in1[k], inj_in2[k]);
        end else if (gnt[k]) begin
          if (mode == M_ALL || (mode == M_RAND && $urandom_range(0, 1) == 1))
            raise(k, 5'($urandom), 8'($urandom), 8'($urandom));
          else
            req[k] = 1'b0;
        end else if (!req[k] && (mode == M_ALL || (mode == M_RAND && $urandom_range(0, 3) == 0))) begin
          raise(k, 5'($urandom), 8'($urandom), 8'($urandom));
        end
      end
      inj_mask = '0;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_missing: no response for requester %0d, required at cycle %0d, now %0d",
                 sb_q[0].who, sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (rsp_valid != '0) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.who);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_status", 32'(rsp_status), 32'(e.status));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_alu_enable"}, 32'(alu_enable), 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    chk({tag, "_alu_in1"}, 32'(alu_in1), 32'h0);
    chk({tag, "_alu_in2"}, 32'(alu_in2), 32'h0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'h0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
    chk({tag, "_rsp_status"}, 32'(rsp_status), 32'h0);
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(m_idle && req == '0 && sb_q.size() == 0) && n < 400);
    if (n >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, queue=%0d req=%b", tag, n, sb_q.size(), req);
    end
  endtask

  task automatic inject(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      inj_op[k]  = 5'($urandom);
      inj_in1[k] = 8'($urandom);
      inj_in2[k] = 8'($urandom);
    end
    inj_mask = mask;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // single requester, ALU ready two cycles after enable
    wait_quiet("start");
    inject(4'b0001);
    inj_op[0] = 5'h01; inj_in1[0] = 8'h12; inj_in2[0] = 8'h34;
    fixed_d = 2;
    wait_quiet("single");
    chk("single_data", 32'(rsp_data), 32'h46);
    chk("single_status", 32'(rsp_status), 32'h00);
    chk("single_err", 32'(rsp_err), 32'h0);

    // all requesters held, ALU immediately ready
    fixed_d = 0;
    mode = M_ALL;
    repeat (30) @(negedge clk);
    mode = M_OFF;
    wait_quiet("round_robin");

    // wrap fairness: pointer moved to 3 by serving requester 2, then 3 and 0 compete
    inject(4'b0100);
    wait_quiet("fair_setup");
    inject(4'b1001);
    wait_quiet("fair_wrap");

    // timeout, then a normal operation
    fixed_d = 40;
    inject(4'b0010);
    wait_quiet("timeout");
    chk("timeout_err", 32'(rsp_err), 32'h1);
    chk("timeout_data", 32'(rsp_data), 32'h0);
    chk("timeout_status", 32'(rsp_status), 32'h0);
    fixed_d = 1;
    inject(4'b0100);
    wait_quiet("after_timeout");
    chk("after_timeout_err", 32'(rsp_err), 32'h0);

    // randomized traffic with spurious ready in IDLE/RESP
    fixed_d = -1;
    mode = M_RAND;
    repeat (1500) @(negedge clk);
    mode = M_OFF;
    wait_quiet("random");

    // reset during the second ISSUE cycle
    fixed_d = 5;
    mode = M_ALL;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(m_busy && (cyc - m_g == 1) && cyc < m_rsp_cyc) && n < 100);
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL reset_setup_timeout: never reached second ISSUE cycle");
    end
    reset_n = 1'b0;
    mode = M_OFF;
    sb_q.delete();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    #1;
    fixed_d = 1;
    reset_n = 1'b1;
    wait_quiet("post_reset");

    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU among `N_REQ` requesters. It accepts one operation at a time from the requesters and drives the ALU issue signals (`alu_enable`, `alu_in1`, `alu_in2`, `alu_op`). It then waits for `alu_ready` and routes `alu_out`/`alu_status` back to the originating requester. It sits between the requester blocks and the ALU interface, and a bounded wait aborts any operation the ALU never completes.

## Interface
- `N_REQ`, default 4: number of requesters. Legal range 2..8.
- `TIMEOUT_CYCLES`, default 16: maximum cycles in ISSUE before the operation is aborted. Must be ≥2.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester request. Held high with operands stable until the matching `gnt` pulse.
- `req_op` input 5*N_REQ: opcode. Slice k is bits [5k+4:5k].
- `req_in1` input 8*N_REQ: operand 1, slice k.
- `req_in2` input 8*N_REQ: operand 2, slice k.
- `gnt` output N_REQ: one-hot, one-cycle pulse. Marks acceptance of requester k's operands.
- `rsp_valid` output N_REQ: one-hot, one-cycle pulse. The result for requester k is on `rsp_*`.
- `rsp_data` output 8: result byte.
- `rsp_status` output 5: ALU status flags.
- `rsp_err` output 1: 1 = operation timed out; data and status are zero.
- `alu_enable` output 1: operation issue, level.
- `alu_in1` output 8: operand 1 to the ALU.
- `alu_in2` output 8: operand 2 to the ALU.
- `alu_op` output 5: opcode to the ALU.
- `alu_out` input 8: ALU result. Valid when `alu_ready` = 1.
- `alu_status` input 5: ALU status. Valid when `alu_ready` = 1.
- `alu_ready` input 1: ALU completion, sampled only in ISSUE.

## Operation
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE**
  - If `req` ≠ 0, pick the first set bit searching upward from `rr_ptr` with wrap.
  - At the clock edge: register that requester's op/in1/in2 onto the `alu_*` outputs, set `gnt[k]`, store `owner` = k, set `rr_ptr` = (k+1) mod N_REQ, clear `wait_cnt`, and go to ISSUE.
  - If `req` = 0, stay in IDLE.
- **ISSUE**
  - `alu_enable` = 1 and the `alu_*` operands are held constant.
  - If `alu_ready` = 1 at an edge: capture `alu_out` into `rsp_data`, `alu_status` into `rsp_status`, set `rsp_err` = 0, and go to RESP.
  - Otherwise, if `wait_cnt` = TIMEOUT_CYCLES−1: set `rsp_data` = 0, `rsp_status` = 0, `rsp_err` = 1, and go to RESP.
  - Otherwise, increment `wait_cnt`.
- **RESP**
  - `rsp_valid[owner]` = 1 for exactly this cycle. Go to IDLE.
- `rsp_data`/`rsp_status`/`rsp_err` hold their values until the next capture.
- `alu_ready` in IDLE or RESP is ignored.
- A requester that keeps `req` high after its `gnt` is treated as making a new request. Round-robin still gives the other requesters priority.
- `rr_ptr` is 0 after reset. `wait_cnt` is $clog2(TIMEOUT_CYCLES) bits wide.
- Opcodes and operands pass through unmodified; no opcode decode is done here.

## Timing
- Reset values:
  - `gnt`, `rsp_valid`, `alu_enable`, `rsp_err`: 0.
  - `alu_in1`, `alu_in2`, `alu_op`, `rsp_data`, `rsp_status`: 0.
  - state = IDLE, `rr_ptr` = 0.
- All outputs are registered. No combinational path exists from `req` or `alu_ready` to any output.
- Sequence of a single operation:
  - Cycle T: `req` sampled high.
  - Cycle T+1: `gnt` high and `alu_enable` high.
  - First cycle with `alu_ready` high = C; cycle C+1: `rsp_valid` high.
  - Cycle C+2: back in IDLE; the next grant can appear at C+3.
- Minimum occupancy is 3 cycles per operation (IDLE, ISSUE, RESP). Maximum is TIMEOUT_CYCLES+2.
- `alu_enable` drops in the cycle after `alu_ready` is sampled high.
- Reset asserted mid-operation: all state clears immediately and the in-flight operation is dropped. No `rsp_valid` is issued for it.
- Simultaneous requests are resolved only in IDLE. Requests arriving in ISSUE or RESP wait.

## Test plan
- **Single requester:** req[0] with op=5'h01, in1=8'h12, in2=8'h34; ALU returns ready 2 cycles after enable with out=8'h46, status=5'h00. Expect `gnt[0]` at T+1, `alu_in1`=12/`alu_in2`=34 held through ISSUE, then `rsp_valid[0]` with `rsp_data`=8'h46 and `rsp_err`=0.
- **Round-robin:** `req` = 4'b1111 held continuously, ALU always ready immediately. Expect grant order 0,1,2,3,0 with `gnt` pulses spaced 3 cycles apart.
- **Fairness after wrap:** `rr_ptr` = 3, `req` = 4'b1001. Expect grant to requester 3, then requester 0.
- **Timeout:** `alu_ready` held 0 with TIMEOUT_CYCLES=16. Expect `alu_enable` high for exactly 16 cycles, then `rsp_valid[k]` with `rsp_err`=1 and `rsp_data`=0. The next request is served normally afterwards.
- **Spurious ready:** `alu_ready`=1 while in IDLE and RESP. Expect no state change and no `rsp_valid`.
- **Reset mid-ISSUE:** `reset_n` pulled low during the 2nd ISSUE cycle. Expect all outputs at 0 asynchronously, no `rsp_valid` after release, and the first grant after release going to the lowest pending requester.
